match_ctrl: RTL and testbench



---
 rtl/match_pkg.sv | 33 +++
 rtl/key_press.sv | 38 +++
 rtl/match_ctrl.sv | 179 +++++++++++++++++
 tb/tb_match_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
// Shared types and constants for the match sequencer.
//   match_state_t : 3-bit encoding of the match flow, exported on match_ctrl.state
//   WINNER_*      : codes driven on match_ctrl.winner (3 is reserved for a draw)
//   KEY_*_DEFAULT : default USB keycodes for starting and restarting a match
//   MODE_TITLE    : game_mode value meaning "SoC is on the title screen"
// -----------------------------------------------------------------------------
package match_pkg;

  typedef enum logic [2:0] {
    ST_TITLE     = 3'd0,
    ST_FIGHT     = 3'd1,
    ST_KO        = 3'd2,
    ST_ROUND_END = 3'd3,
    ST_MATCH_END = 3'd4
  } match_state_t;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  localparam logic [7:0] KEY_START_DEFAULT   = 8'h28;
  localparam logic [7:0] KEY_RESTART_DEFAULT = 8'h15;

  localparam logic [2:0] MODE_TITLE = 3'd0;

  // Round tallies stop at 3 instead of wrapping back to 0.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/key_press.sv
// -----------------------------------------------------------------------------
// key_press
// Detects a new press of one key in the 4-byte USB keycode report.
//   frame_clk  : frame clock
//   Reset      : synchronous, active-high
//   i_keycodes : four concurrent keycodes, one per byte
//   i_key      : keycode to watch for
//   o_press    : high for the first frame in which i_key appears in any byte
// The previous-hit flag is registered; the pulse is formed against it so the
// sequencer can react at the very next frame edge.
// -----------------------------------------------------------------------------
module key_press (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] i_keycodes,
  input  logic [7:0]  i_key,
  output logic        o_press
);

  logic w_hit;
  logic r_prev_hit;

  assign w_hit = (i_keycodes[7:0]   == i_key) ||
                 (i_keycodes[15:8]  == i_key) ||
                 (i_keycodes[23:16] == i_key) ||
                 (i_keycodes[31:24] == i_key);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  // Reset value is 1 so a key already held when reset releases is not a press.
  always_ff @(posedge frame_clk) begin
    if (Reset) r_prev_hit <= 1'b1;
    else       r_prev_hit <= w_hit;
  end

  assign o_press = w_hit & ~r_prev_hit;

endmodule

// File: rtl/match_ctrl.sv
// -----------------------------------------------------------------------------
// match_ctrl
// Frame-rate match sequencer: title -> fight -> KO -> round end / match end.
//   frame_clk          : frame clock (vertical sync), one cycle per video frame
//   Reset              : synchronous, active-high
//   keycodes[31:0]     : four concurrent USB keycodes
//   game_mode[2:0]     : 0 title, 1 vs AI, 2 vs player
//   p1_lose / p2_lose  : health exhausted flags from the health stages
//   state[2:0]         : current match_state_t
//   count[8:0]         : post-KO frame counter
//   freeze             : suppress fighter movement and attacks
//   round_rst          : one-frame pulse resetting positions and health
//   p1_wins / p2_wins  : round tallies (saturate at 3)
//   winner[1:0]        : 0 none, 1 P1, 2 P2; set when the match ends
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module match_ctrl
  import match_pkg::*;
#(
  parameter int unsigned KO_FRAMES     = 50,
  parameter int unsigned WINS_TO_MATCH = 2,
  parameter logic [7:0]  KEY_START     = KEY_START_DEFAULT,
  parameter logic [7:0]  KEY_RESTART   = KEY_RESTART_DEFAULT
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycodes,
  input  logic [2:0]  game_mode,
  input  logic        p1_lose,
  input  logic        p2_lose,
  output logic [2:0]  state,
  output logic [8:0]  count,
  output logic        freeze,
  output logic        round_rst,
  output logic [1:0]  p1_wins,
  output logic [1:0]  p2_wins,
  output logic [1:0]  winner
);

  localparam logic [8:0] KO_LAST  = 9'(KO_FRAMES);
  localparam logic [1:0] WIN_GOAL = 2'(WINS_TO_MATCH);

  logic w_start_press;
  logic w_restart_press;

  match_state_t r_state,   w_state;
  logic [8:0]   r_count,   w_count;
  logic         r_freeze,  w_freeze;
  logic         r_round_rst, w_round_rst;
  logic [1:0]   r_p1_wins, w_p1_wins;
  logic [1:0]   r_p2_wins, w_p2_wins;
  logic [1:0]   r_winner,  w_winner;

  key_press u_key_start (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .i_keycodes (keycodes),
    .i_key      (KEY_START),
    .o_press    (w_start_press)
  );

  key_press u_key_restart (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .i_keycodes (keycodes),
    .i_key      (KEY_RESTART),
    .o_press    (w_restart_press)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_p1_wins   = r_p1_wins;
    w_p2_wins   = r_p2_wins;
    w_winner    = r_winner;
    w_round_rst = 1'b0;

    // Leaving the match from the SoC side overrides everything else.
    if ((r_state != ST_TITLE) && (game_mode == MODE_TITLE)) begin
      w_state   = ST_TITLE;
      w_count   = '0;
      w_p1_wins = '0;
      w_p2_wins = '0;
      w_winner  = WINNER_NONE;
    end else begin
      case (r_state)
        ST_TITLE: begin
          if (w_start_press && (game_mode != MODE_TITLE)) begin
            w_state     = ST_FIGHT;
            w_count     = '0;
            w_p1_wins   = '0;
            w_p2_wins   = '0;
            w_winner    = WINNER_NONE;
            w_round_rst = 1'b1;
          end
        end

        ST_FIGHT: begin
          if (p1_lose || p2_lose) begin
            w_state = ST_KO;
            w_count = '0;
            // A double KO is a draw and leaves both tallies alone.
            if (p1_lose && !p2_lose) w_p2_wins = sat_inc2(r_p2_wins);
            if (p2_lose && !p1_lose) w_p1_wins = sat_inc2(r_p1_wins);
          end
        end

        ST_KO: begin
          if (r_count == KO_LAST) begin
            if (r_p1_wins == WIN_GOAL) begin
              w_state  = ST_MATCH_END;
              w_winner = WINNER_P1;
            end else if (r_p2_wins == WIN_GOAL) begin
              w_state  = ST_MATCH_END;
              w_winner = WINNER_P2;
            end else begin
              w_state  = ST_ROUND_END;
            end
          end else begin
            w_count = r_count + 9'd1;
          end
        end

        ST_ROUND_END: begin
          if (w_restart_press) begin
            w_state     = ST_FIGHT;
            w_count     = '0;
            w_round_rst = 1'b1;
          end
        end

        ST_MATCH_END: begin
          if (w_restart_press) begin
            w_state   = ST_TITLE;
            w_count   = '0;
            w_p1_wins = '0;
            w_p2_wins = '0;
            w_winner  = WINNER_NONE;
          end
        end

        default: w_state = ST_TITLE;
      endcase
    end

    w_freeze = (w_state != ST_FIGHT);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state     <= ST_TITLE;
      r_count     <= '0;
      r_freeze    <= 1'b1;
      r_round_rst <= 1'b0;
      r_p1_wins   <= '0;
      r_p2_wins   <= '0;
      r_winner    <= WINNER_NONE;
    end else begin
      r_state     <= w_state;
      r_count     <= w_count;
      r_freeze    <= w_freeze;
      r_round_rst <= w_round_rst;
      r_p1_wins   <= w_p1_wins;
      r_p2_wins   <= w_p2_wins;
      r_winner    <= w_winner;
    end
  end

  assign state     = r_state;
  assign count     = r_count;
  assign freeze    = r_freeze;
  assign round_rst = r_round_rst;
  assign p1_wins   = r_p1_wins;
  assign p2_wins   = r_p2_wins;
  assign winner    = r_winner;

endmodule

// File: tb/tb_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_match_ctrl
// Self-checking bench for match_ctrl. Each scenario task builds a short table
// of per-frame inputs and the outputs expected in the following frame; the
// expectation is queued when the inputs are driven and popped and compared
// once the frame edge has produced the DUT's response.
// -----------------------------------------------------------------------------
module tb_match_ctrl;
  import match_pkg::*;

  localparam int KO = 50;

  localparam logic [2:0] T  = 3'd0;
  localparam logic [2:0] F  = 3'd1;
  localparam logic [2:0] K  = 3'd2;
  localparam logic [2:0] RE = 3'd3;
  localparam logic [2:0] ME = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] cnt;
    logic       frz;
    logic       rr;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] win;
  } snap_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] kc;
    logic [2:0]  mode;
    logic        l1;
    logic        l2;
  } stim_t;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [31:0] keycodes  = '0;
  logic [2:0]  game_mode = 3'd1;
  logic        p1_lose   = 1'b0;
  logic        p2_lose   = 1'b0;
  logic [2:0]  state;
  logic [8:0]  count;
  logic        freeze;
  logic        round_rst;
  logic [1:0]  p1_wins;
  logic [1:0]  p2_wins;
  logic [1:0]  winner;

  snap_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  match_ctrl #(
    .KO_FRAMES     (KO),
    .WINS_TO_MATCH (2),
    .KEY_START     (8'h28),
    .KEY_RESTART   (8'h15)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycodes  (keycodes),
    .game_mode (game_mode),
    .p1_lose   (p1_lose),
    .p2_lose   (p2_lose),
    .state     (state),
    .count     (count),
    .freeze    (freeze),
    .round_rst (round_rst),
    .p1_wins   (p1_wins),
    .p2_wins   (p2_wins),
    .winner    (winner)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic stim_t mk_in(logic rst, logic [31:0] kc, logic [2:0] mode,
                                  logic l1, logic l2);
    return '{rst: rst, kc: kc, mode: mode, l1: l1, l2: l2};
  endfunction

  function automatic snap_t mk_out(logic [2:0] st, int cnt, logic frz, logic rr,
                                   int p1, int p2, int win);
    return '{st: st, cnt: 9'(cnt), frz: frz, rr: rr,
             p1: 2'(p1), p2: 2'(p2), win: 2'(win)};
  endfunction

  function automatic snap_t observed();
    return '{st: state, cnt: count, frz: freeze, rr: round_rst,
             p1: p1_wins, p2: p2_wins, win: winner};
  endfunction

  task automatic drive(input stim_t s);
    Reset     = s.rst;
    keycodes  = s.kc;
    game_mode = s.mode;
    p1_lose   = s.l1;
    p2_lose   = s.l2;
  endtask

  // Advance one frame and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Idle frames through KO: count climbs to KO, then the flow moves on.
  task automatic test_ko_run(input logic [2:0] mode, input int p1, input int p2,
                             input logic [2:0] final_st, input int win);
    snap_t exp, got;
    for (int i = 1; i <= KO + 1; i++) begin
      drive(mk_in(1'b0, 32'h0, mode, 1'b0, 1'b0));
      if (i <= KO) sb_q.push_back(mk_out(K, i, 1'b1, 1'b0, p1, p2, 0));
      else         sb_q.push_back(mk_out(final_st, KO, 1'b1, 1'b0, p1, p2, win));
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL ko_run[%0d]: got %p expected %p", i, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    stim_t s[$];
    snap_t e[$];
    snap_t exp, got;
    // Start key held through reset must not count as a press.
    s.push_back(mk_in(1, 32'h0000_0028, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(1, 32'h0000_0028, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0028, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0028, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset[%0d]: got %p expected %p", i, got, exp);
      end
    end
  endtask

  task automatic test_start();
    stim_t s[$];
    snap_t e[$];
    snap_t exp, got;
    s.push_back(mk_in(0, 32'h0000_0028, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 1, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0028, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL start[%0d]: got %p expected %p", i, got, exp);
      end
    end
  endtask

  // Player 1 takes two rounds; restart key arrives in byte 3.
  task automatic test_match_p1();
    snap_t exp, got;
    stim_t s[$];
    snap_t e[$];
    drive(mk_in(0, 32'h0, 1, 0, 1));
    sb_q.push_back(mk_out(K, 0, 1, 0, 1, 0, 0));
    tick();
    got = observed();
    exp = sb_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL p1_ko1: got %p expected %p", got, exp);
    end
    test_ko_run(3'd1, 1, 0, RE, 0);
    // Lose flag ignored outside FIGHT, even while the restart press lands.
    s.push_back(mk_in(0, 32'h0000_0000, 1, 1, 0)); e.push_back(mk_out(RE, KO, 1, 0, 1, 0, 0));
    s.push_back(mk_in(0, 32'h1500_0000, 1, 1, 0)); e.push_back(mk_out(F, 0, 0, 1, 1, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 0, 1, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 1)); e.push_back(mk_out(K, 0, 1, 0, 2, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL p1_round2[%0d]: got %p expected %p", i, got, exp);
      end
    end
    test_ko_run(3'd1, 2, 0, ME, 1);
    s.delete();
    e.delete();
    s.push_back(mk_in(0, 32'h0000_0000, 1, 1, 1)); e.push_back(mk_out(ME, KO, 1, 0, 2, 0, 1));
    s.push_back(mk_in(0, 32'h0000_0015, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL p1_match_end[%0d]: got %p expected %p", i, got, exp);
      end
    end
  endtask

  task automatic test_draw();
    stim_t s[$];
    snap_t e[$];
    snap_t exp, got;
    s.push_back(mk_in(0, 32'h0028_0000, 2, 0, 0)); e.push_back(mk_out(F, 0, 0, 1, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 2, 1, 1)); e.push_back(mk_out(K, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL draw[%0d]: got %p expected %p", i, got, exp);
      end
    end
    test_ko_run(3'd2, 0, 0, RE, 0);
  endtask

  // Abort from KO at count 20, then a start press in title mode is ignored.
  task automatic test_abort();
    stim_t s[$];
    snap_t e[$];
    snap_t exp, got;
    s.push_back(mk_in(0, 32'h0015_0000, 2, 0, 0)); e.push_back(mk_out(F, 0, 0, 1, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 2, 1, 0)); e.push_back(mk_out(K, 0, 1, 0, 0, 1, 0));
    for (int c = 1; c <= 20; c++) begin
      s.push_back(mk_in(0, 32'h0, 2, 0, 0));       e.push_back(mk_out(K, c, 1, 0, 0, 1, 0));
    end
    s.push_back(mk_in(0, 32'h0000_0000, 0, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0028, 0, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL abort[%0d]: got %p expected %p", i, got, exp);
      end
    end
  endtask

  // Player 2 takes the match, then an abort from MATCH_END clears it.
  task automatic test_match_p2();
    stim_t s[$];
    snap_t e[$];
    snap_t exp, got;
    s.push_back(mk_in(0, 32'h0000_2800, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 1, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 1, 0)); e.push_back(mk_out(K, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL p2_round1[%0d]: got %p expected %p", i, got, exp);
      end
    end
    test_ko_run(3'd1, 0, 1, RE, 0);
    s.delete();
    e.delete();
    s.push_back(mk_in(0, 32'h0000_0015, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 1, 0, 1, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 1, 0)); e.push_back(mk_out(K, 0, 1, 0, 0, 2, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL p2_round2[%0d]: got %p expected %p", i, got, exp);
      end
    end
    test_ko_run(3'd1, 0, 2, ME, 2);
    drive(mk_in(0, 32'h0, 0, 0, 0));
    sb_q.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    tick();
    got = observed();
    exp = sb_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL p2_abort_match_end: got %p expected %p", got, exp);
    end
  endtask

  // Reset arriving together with a lose flag mid-round wins.
  task automatic test_reset_mid_round();
    stim_t s[$];
    snap_t e[$];
    snap_t exp, got;
    s.push_back(mk_in(0, 32'h0000_0028, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 1, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 0)); e.push_back(mk_out(F, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_in(1, 32'h0000_0000, 1, 0, 1)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    s.push_back(mk_in(0, 32'h0000_0000, 1, 0, 0)); e.push_back(mk_out(T, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      tick();
      got = observed();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_mid_round[%0d]: got %p expected %p", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_match_p1();
    test_draw();
    test_abort();
    test_match_p2();
    test_reset_mid_round();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
